ks_prefix_pipe: RTL and testbench

- Pipelined Kogge-Stone prefix network and sum stage for the 16-bit adder.
- Sits directly downstream of the per-bit propagate/generate stage and consumes its 16 {P,G} pairs plus a carry-in.
- Produces sum, carry-out and signed overflow behind a valid/ready handshake.
- Pipeline depth is selectable at compile time.

---
 rtl/ks_pkg.sv | 24 ++
 rtl/ks_prefix_level.sv | 21 ++
 rtl/ks_prefix_pipe.sv | 157 +++++++++++++++
 tb/tb_ks_prefix_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and the prefix-cell helper for the 16-bit Kogge-Stone adder.
// Optional build macro used by the top: KS_PIPE_REG_EN.
package ks_pkg;

    localparam int KS_WIDTH  = 16;
    localparam int KS_LEVELS = 4;

    // One propagate/generate pair; p is the upper bit to match pg_in packing.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    typedef pg_t [KS_WIDTH-1:0] pg_vec_t;

    // Combine a higher-order span with the adjacent lower-order span.
    function automatic pg_t black_cell(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone level: black cells at distance DIST,
// pass-through for the low DIST positions.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH,
    parameter int DIST  = 1
) (
    input  pg_t [WIDTH-1:0] pg_i,
    output pg_t [WIDTH-1:0] pg_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i >= DIST) begin : g_black
            assign pg_o[i] = black_cell(pg_i[i], pg_i[i-DIST]);
        end else begin : g_pass
            assign pg_o[i] = pg_i[i];
        end
    end

endmodule

// File: rtl/ks_prefix_pipe.sv
// Pipelined Kogge-Stone prefix network plus sum stage with valid/ready.
// Build option: define KS_PIPE_REG_EN for a register after every prefix level
// (depth LEVELS); otherwise everything is combinational into one output register.
// The whole pipe advances together: a stalled output freezes every stage.
module ks_prefix_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] pg_in,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    logic                  advance_s;
    pg_t  [WIDTH-1:0]      pg_in_s;
    pg_t  [WIDTH-1:0]      entry_s;
    logic [WIDTH-1:0]      porig_s;
    pg_t  [WIDTH-1:0]      lvl_in_s  [LEVELS];
    pg_t  [WIDTH-1:0]      lvl_out_s [LEVELS];

    pg_t  [WIDTH-1:0]      fin_pg_s;
    logic [WIDTH-1:0]      fin_porig_s;
    logic                  fin_cin_s;
    logic                  fin_vld_s;
    logic [WIDTH-1:0]      carry_s;
    logic [WIDTH-1:0]      unused_p_s;

    logic [WIDTH-1:0]      sum_d,  sum_q;
    logic                  cout_d, cout_q;
    logic                  ovf_d,  ovf_q;
    logic                  vld_q;

    assign advance_s = !vld_q || out_ready;
    assign in_ready  = advance_s;
    assign pg_in_s   = pg_in;

    // Fold carry-in into bit 0 generate and split out the original propagates.
    always_comb begin
        entry_s      = pg_in_s;
        entry_s[0].g = pg_in_s[0].g | (pg_in_s[0].p & cin);
        porig_s      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            porig_s[i] = pg_in_s[i].p;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (32'd1 << k)
        ) u_level (
            .pg_i (lvl_in_s[k]),
            .pg_o (lvl_out_s[k])
        );
    end

`ifdef KS_PIPE_REG_EN
    pg_t  [WIDTH-1:0] stg_pg_q  [LEVELS-1];
    logic [WIDTH-1:0] stg_p_q   [LEVELS-1];
    logic             stg_cin_q [LEVELS-1];
    logic             stg_vld_q [LEVELS-1];

    for (genvar k = 0; k < LEVELS; k++) begin : g_link
        if (k == 0) begin : g_first
            assign lvl_in_s[k] = entry_s;
        end else begin : g_reg
            assign lvl_in_s[k] = stg_pg_q[k-1];
        end
    end

    // Inter-level stage registers; the last level feeds the sum logic directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEVELS-1; k++) begin
                stg_pg_q[k]  <= '0;
                stg_p_q[k]   <= '0;
                stg_cin_q[k] <= 1'b0;
                stg_vld_q[k] <= 1'b0;
            end
        end else if (advance_s) begin
            stg_pg_q[0]  <= lvl_out_s[0];
            stg_p_q[0]   <= porig_s;
            stg_cin_q[0] <= cin;
            stg_vld_q[0] <= in_valid;
            for (int k = 1; k < LEVELS-1; k++) begin
                stg_pg_q[k]  <= lvl_out_s[k];
                stg_p_q[k]   <= stg_p_q[k-1];
                stg_cin_q[k] <= stg_cin_q[k-1];
                stg_vld_q[k] <= stg_vld_q[k-1];
            end
        end
    end

    assign fin_porig_s = stg_p_q[LEVELS-2];
    assign fin_cin_s   = stg_cin_q[LEVELS-2];
    assign fin_vld_s   = stg_vld_q[LEVELS-2];
`else
    for (genvar k = 0; k < LEVELS; k++) begin : g_link
        if (k == 0) begin : g_first
            assign lvl_in_s[k] = entry_s;
        end else begin : g_chain
            assign lvl_in_s[k] = lvl_out_s[k-1];
        end
    end

    assign fin_porig_s = porig_s;
    assign fin_cin_s   = cin;
    assign fin_vld_s   = in_valid;
`endif

    assign fin_pg_s = lvl_out_s[LEVELS-1];

    // After the last level each group generate is the carry out of that bit.
    always_comb begin
        carry_s    = '0;
        unused_p_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_s[i]    = fin_pg_s[i].g;
            unused_p_s[i] = fin_pg_s[i].p;
        end
        sum_d  = fin_porig_s ^ {carry_s[WIDTH-2:0], fin_cin_s};
        cout_d = carry_s[WIDTH-1];
        ovf_d  = carry_s[WIDTH-1] ^ carry_s[WIDTH-2];
    end

    // Output register: holds while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else if (advance_s) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            vld_q  <= fin_vld_s;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Self-checking bench for ks_prefix_pipe: directed table, reset cases,
// back-pressure, bubbles and a random throughput run against A+B+cin.
module tb_ks_prefix_pipe;
    import ks_pkg::*;

    localparam int W = 16;
`ifdef KS_PIPE_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] pg_in = '0;
    logic           cin = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out = 0;
    int first_out = 0;
    int last_out = 0;

    logic [15:0] cur_a = '0;
    logic [15:0] cur_b = '0;
    logic        cur_c = 1'b0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    res_t exp_q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    ks_prefix_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pg_in     (pg_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    function automatic logic [2*W-1:0] mk_pg(input logic [15:0] a, input logic [15:0] b);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = a[i] ^ b[i];
            r[2*i]   = a[i] & b[i];
        end
        return r;
    endfunction

    // Reference: plain integer addition; overflow from operand/result signs.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        res_t r;
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b} + {16'd0, c};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        cur_a = a;
        cur_b = b;
        cur_c = c;
        pg_in = mk_pg(a, b);
        cin   = c;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on input transfer, compare in order on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_sum",  {16'd0, sum},  {16'd0, e.sum});
                    check("sb_cout", {31'd0, cout}, {31'd0, e.cout});
                    check("sb_ovf",  {31'd0, ovf},  {31'd0, e.ovf});
                end
                if (n_out == 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(cur_a, cur_b, cur_c));
        end
    end

    task automatic do_single(input vec_t v);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(v.a, v.b, v.c);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency",  n, LAT);
        check("dir_sum",  {16'd0, sum},  {16'd0, v.s});
        check("dir_cout", {31'd0, cout}, {31'd0, v.co});
        check("dir_ovf",  {31'd0, ovf},  {31'd0, v.ov});
        @(posedge clk); #1;
    endtask

    // mode 0: continuous full throughput; mode 1: out_ready low on cycles 3..6.
    task automatic run_stream(input int n_ops, input int mode);
        logic [15:0] a, b;
        logic        c;
        logic        acc;
        logic        hold_ov;
        logic [15:0] h_sum;
        logic        h_cout, h_ovf;
        int idx, ci, bound;
        idx = 0; ci = 0; acc = 1'b0; hold_ov = 1'b0;
        h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
        bound = n_ops * 4 + 100;
        n_out = 0;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
        while ((idx < n_ops || exp_q.size() != 0) && ci < bound) begin
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            end
            out_ready = (mode == 1) ? !(ci >= 3 && ci <= 6) : 1'b1;
            in_valid  = (idx < n_ops);
            set_op(a, b, c);
            #1;
            acc = in_valid && in_ready;
            if (mode == 1 && !out_ready && out_valid) begin
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                if (hold_ov) begin
                    check("bp_hold_sum",  {16'd0, sum},  {16'd0, h_sum});
                    check("bp_hold_cout", {31'd0, cout}, {31'd0, h_cout});
                    check("bp_hold_ovf",  {31'd0, ovf},  {31'd0, h_ovf});
                end
                hold_ov = 1'b1;
                h_sum = sum; h_cout = cout; h_ovf = ovf;
            end else begin
                hold_ov = 1'b0;
            end
            if (mode == 0 && idx < n_ops) check("thr_in_ready", {31'd0, in_ready}, 32'd1);
            ci++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_done", {31'd0, (idx == n_ops && exp_q.size() == 0)}, 32'd1);
        check("stream_count", n_out, n_ops);
        if (mode == 0) check("throughput_span", last_out - first_out, n_ops - 1);
    endtask

    task automatic run_bubbles();
        logic iv[16];
        logic ov[16];
        out_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            @(posedge clk); #1;
            ov[s] = out_valid;
            in_valid = (s < 8) && (s % 2 == 0);
            iv[s] = in_valid;
            set_op(16'($urandom), 16'($urandom), 1'($urandom));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int s = 0; s + LAT < 16; s++) begin
            check("bubble_pattern", {31'd0, ov[s+LAT]}, {31'd0, iv[s]});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

        // Reset held with input offered.
        rst_n = 1'b0;
        in_valid = 1'b1;
        set_op(16'hFFFF, 16'h0001, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_sum",       {16'd0, sum},       32'd0);
            check("rst_cout",      {31'd0, cout},      32'd0);
            check("rst_ovf",       {31'd0, ovf},       32'd0);
            check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 6; i++) do_single(tbl[i]);

        run_stream(8, 1);
        run_bubbles();
        repeat (LAT + 2) @(posedge clk);
        run_stream(1000, 0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = 1'b1;
            set_op(16'($urandom), 16'($urandom), 1'($urandom));
        end
        @(posedge clk); #3;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_sum",   {16'd0, sum},       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LAT + 3) begin
            @(negedge clk);
            check("no_ghost_output", {31'd0, out_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
